// File: rtl/atm_session_ctrl_pkg.sv
// Shared codes for the ATM session front-end: core action codes, keypad codes,
// error codes and FSM state encoding.
package atm_session_ctrl_pkg;

    localparam logic [2:0] ACT_NOP       = 3'b000;
    localparam logic [2:0] ACT_BALANCE   = 3'b011;
    localparam logic [2:0] ACT_WITHDRAW  = 3'b100;
    localparam logic [2:0] ACT_DEPOSIT   = 3'b101;
    localparam logic [2:0] ACT_TRANSFER  = 3'b110;
    localparam logic [2:0] ACT_PINCHANGE = 3'b111;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_BAD_PIN   = 3'd1,
        ERR_RETAINED  = 3'd2,
        ERR_TXN_FAIL  = 3'd3,
        ERR_AMT_OVF   = 3'd4,
        ERR_CANCELLED = 3'd5,
        ERR_TIMEOUT   = 3'd6
    } err_e;

    localparam logic [3:0] ST_IDLE         = 4'd0;
    localparam logic [3:0] ST_PIN_ENTRY    = 4'd1;
    localparam logic [3:0] ST_ISSUE        = 4'd2;
    localparam logic [3:0] ST_WAIT         = 4'd3;
    localparam logic [3:0] ST_MENU         = 4'd4;
    localparam logic [3:0] ST_AMT_ENTRY    = 4'd5;
    localparam logic [3:0] ST_DEST_ENTRY   = 4'd6;
    localparam logic [3:0] ST_NEWPIN_ENTRY = 4'd7;
    localparam logic [3:0] ST_EJECT        = 4'd8;
    localparam logic [3:0] ST_RETAIN       = 4'd9;

    // States where the user is typing: cancel, timeout and card removal apply here.
    function automatic logic is_input_state(input logic [3:0] st);
        return (st == ST_PIN_ENTRY) || (st == ST_MENU) || (st == ST_AMT_ENTRY) ||
               (st == ST_DEST_ENTRY) || (st == ST_NEWPIN_ENTRY);
    endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Request/response bus between the session front-end (master) and the ATM core (slave).
interface atm_session_ctrl_if;
    logic [11:0] accNumber;
    logic [3:0]  pin;
    logic [2:0]  action;
    logic [15:0] amount;
    logic        pinChange;
    logic [3:0]  newPin;
    logic [11:0] destinationAcc;
    logic        atmReq;
    logic        atmSuccess;
    logic        atmPinOk;

    modport master (
        output accNumber, pin, action, amount, pinChange, newPin, destinationAcc, atmReq,
        input  atmSuccess, atmPinOk
    );
    modport slave (
        input  accNumber, pin, action, amount, pinChange, newPin, destinationAcc, atmReq,
        output atmSuccess, atmPinOk
    );
endinterface

// File: rtl/atm_amount_accum.sv
// Decimal amount accumulator: amount = amount*10 + digit, rejecting digits that
// would exceed 16 bits or the digit limit.
module atm_amount_accum #(
    parameter int MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        digit_vld,
    input  logic [3:0]  digit,
    output logic [15:0] amount,
    output logic        reject
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [CW-1:0] cnt;
    logic [16:0]   nxt;

    // 17 bits is enough: the digit limit caps amount at 9999 before the last digit.
    assign nxt    = {1'b0, amount} * 17'd10 + {13'd0, digit};
    assign reject = digit_vld && ((cnt == CW'(MAX_DIGITS)) || nxt[16]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amount <= '0;
            cnt    <= '0;
        end else if (clr) begin
            amount <= '0;
            cnt    <= '0;
        end else if (digit_vld && !reject) begin
            amount <= nxt[15:0];
            cnt    <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session front-end: card, keypad and menu capture, PIN verification and
// request windows toward the core. Define SESSION_TIMEOUT_EN for the inactivity timeout.
module atm_session_ctrl
    import atm_session_ctrl_pkg::*;
#(
    parameter int MAX_PIN_TRIES  = 3,
    parameter int ATM_LATENCY    = 1,
    parameter int MAX_AMT_DIGITS = 5,
    parameter int IDLE_TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cardInserted,
    input  logic [11:0] cardAcc,
    input  logic        keyValid,
    input  logic [3:0]  keyCode,
    input  logic        menuValid,
    input  logic [2:0]  menuSel,
    atm_session_ctrl_if.master core,
    output logic        resultValid,
    output logic        resultOk,
    output logic        cardEject,
    output logic        cardRetained,
    output logic [2:0]  errCode
);
    logic [3:0]  state;
    logic        card_q, has_digit, chk, abort, req_r, pinchg_r;
    logic [11:0] acc, dest_r;
    logic [3:0]  pin_r, newpin_r, lat_cnt;
    logic [2:0]  action_r, sel, fail_cnt, dcnt;
    logic [15:0] amt;
    logic        amt_reject, acc_clr, acc_dig;
    logic        is_digit, is_enter, is_cancel, is_clear;
    logic        in_session, win_end, drop, tmo, live, txn_ok;

    assign is_digit   = keyValid && (keyCode <= 4'd9);
    assign is_enter   = keyValid && (keyCode == KEY_ENTER);
    assign is_cancel  = keyValid && (keyCode == KEY_CANCEL);
    assign is_clear   = keyValid && (keyCode == KEY_CLEAR);
    assign in_session = is_input_state(state);
    assign win_end    = (state == ST_WAIT) && (lat_cnt == 4'(ATM_LATENCY));
    // Card gone: leave at once while typing, only at the end of a request window,
    // and once it is pulled in EJECT/RETAIN.
    assign drop = !cardInserted && (in_session || state == ST_EJECT || state == ST_RETAIN) ||
                  (win_end && (abort || !cardInserted));
    assign live = !drop && !(in_session && (tmo || is_cancel));
    assign txn_ok = (action_r == ACT_PINCHANGE) ? (core.atmSuccess & core.atmPinOk)
                                                : core.atmSuccess;

    assign acc_dig = live && (state == ST_AMT_ENTRY) && is_digit;
    assign acc_clr = drop || (live && (((state == ST_MENU) && menuValid &&
                     (menuSel == ACT_WITHDRAW || menuSel == ACT_DEPOSIT || menuSel == ACT_TRANSFER)) ||
                     ((state == ST_AMT_ENTRY) && is_clear)));

`ifdef SESSION_TIMEOUT_EN
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                                  idle_cnt <= '0;
        else if (keyValid || menuValid || state == ST_IDLE)        idle_cnt <= '0;
        else if (in_session && idle_cnt != TW'(IDLE_TIMEOUT))      idle_cnt <= idle_cnt + 1'b1;
    end
    assign tmo = in_session && (idle_cnt == TW'(IDLE_TIMEOUT));
`else
    assign tmo = 1'b0;
`endif

    atm_amount_accum #(.MAX_DIGITS(MAX_AMT_DIGITS)) u_amt (
        .clk(clk), .rst(rst), .clr(acc_clr), .digit_vld(acc_dig), .digit(keyCode),
        .amount(amt), .reject(amt_reject)
    );

    assign core.accNumber      = acc;
    assign core.pin            = pin_r;
    assign core.action         = action_r;
    assign core.amount         = amt;
    assign core.pinChange      = pinchg_r;
    assign core.newPin         = newpin_r;
    assign core.destinationAcc = dest_r;
    assign core.atmReq         = req_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;  card_q <= 1'b0;  has_digit <= 1'b0;  chk <= 1'b0;
            abort <= 1'b0;     req_r <= 1'b0;   pinchg_r <= 1'b0;   acc <= '0;
            dest_r <= '0;      pin_r <= '0;     newpin_r <= '0;     lat_cnt <= '0;
            action_r <= ACT_NOP; sel <= '0;     fail_cnt <= '0;     dcnt <= '0;
            resultValid <= 1'b0; resultOk <= 1'b0; cardEject <= 1'b0;
            cardRetained <= 1'b0; errCode <= ERR_NONE;
        end else begin
            card_q      <= cardInserted;
            req_r       <= 1'b0;
            resultValid <= 1'b0;
            resultOk    <= 1'b0;
            cardEject   <= 1'b0;
            if (drop) begin
                state <= ST_IDLE;  acc <= '0;  pin_r <= '0;  newpin_r <= '0;  dest_r <= '0;
                dcnt <= '0;  pinchg_r <= 1'b0;  action_r <= ACT_NOP;  has_digit <= 1'b0;
            end else if (in_session && (tmo || is_cancel)) begin
                errCode   <= tmo ? ERR_TIMEOUT : ERR_CANCELLED;
                cardEject <= 1'b1;
                state     <= ST_EJECT;
            end else begin
                case (state)
                    ST_IDLE: if (cardInserted && !card_q) begin
                        acc <= cardAcc;  errCode <= ERR_NONE;  fail_cnt <= '0;  has_digit <= 1'b0;
                        state <= ST_PIN_ENTRY;
                    end
                    ST_PIN_ENTRY: if (is_digit) begin
                        pin_r <= keyCode;  has_digit <= 1'b1;
                    end else if (is_enter && has_digit) begin
                        action_r <= ACT_BALANCE;  req_r <= 1'b1;  chk <= 1'b1;  state <= ST_ISSUE;
                    end
                    ST_MENU: if (menuValid) begin
                        case (menuSel)
                            ACT_BALANCE: begin
                                sel <= menuSel;  action_r <= ACT_BALANCE;  req_r <= 1'b1;
                                chk <= 1'b0;     state <= ST_ISSUE;
                            end
                            ACT_WITHDRAW, ACT_DEPOSIT, ACT_TRANSFER: begin
                                sel <= menuSel;  state <= ST_AMT_ENTRY;
                            end
                            ACT_PINCHANGE: begin
                                sel <= menuSel;  newpin_r <= '0;  state <= ST_NEWPIN_ENTRY;
                            end
                            default: ;
                        endcase
                    end
                    ST_AMT_ENTRY: if (amt_reject) begin
                        errCode <= ERR_AMT_OVF;
                    end else if (is_enter && amt != 16'd0) begin
                        if (sel == ACT_TRANSFER) begin
                            dest_r <= '0;  dcnt <= '0;  state <= ST_DEST_ENTRY;
                        end else begin
                            action_r <= sel;  req_r <= 1'b1;  chk <= 1'b0;  state <= ST_ISSUE;
                        end
                    end
                    ST_DEST_ENTRY: if (is_digit) begin
                        dest_r <= {dest_r[7:0], keyCode};
                        if (dcnt != 3'd7) dcnt <= dcnt + 3'd1;
                    end else if (is_clear) begin
                        dest_r <= '0;  dcnt <= '0;
                    end else if (is_enter && dcnt == 3'd3) begin
                        action_r <= ACT_TRANSFER;  req_r <= 1'b1;  chk <= 1'b0;  state <= ST_ISSUE;
                    end
                    ST_NEWPIN_ENTRY: if (is_digit) begin
                        newpin_r <= keyCode;
                    end else if (is_enter) begin
                        pinchg_r <= 1'b1;  action_r <= ACT_PINCHANGE;  req_r <= 1'b1;
                        chk <= 1'b0;       state <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        lat_cnt <= 4'd1;  abort <= !cardInserted;  state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (!cardInserted) abort <= 1'b1;
                        if (win_end) begin
                            action_r <= ACT_NOP;  pinchg_r <= 1'b0;
                            if (chk) begin
                                if (core.atmSuccess) begin
                                    fail_cnt <= '0;  state <= ST_MENU;
                                end else begin
                                    fail_cnt <= fail_cnt + 3'd1;  has_digit <= 1'b0;
                                    if (fail_cnt + 3'd1 == 3'(MAX_PIN_TRIES)) begin
                                        cardRetained <= 1'b1;  errCode <= ERR_RETAINED;  state <= ST_RETAIN;
                                    end else begin
                                        errCode <= ERR_BAD_PIN;  state <= ST_PIN_ENTRY;
                                    end
                                end
                            end else begin
                                resultValid <= 1'b1;  resultOk <= txn_ok;
                                if (!txn_ok) errCode <= ERR_TXN_FAIL;
                                state <= ST_MENU;
                            end
                        end else begin
                            lat_cnt <= lat_cnt + 4'd1;
                        end
                    end
                    default: ;  // EJECT / RETAIN only leave through card removal
                endcase
            end
        end
    end
endmodule
